// File: rtl/sargantana_icache_ctrl.sv
// Sequencing controller for the instruction-cache pipeline stage.
// Accepts a fetch and waits for translation. It then either answers from a
// tag hit or runs a line fill into a chosen victim way and replays the
// response. A flush walks every set once.
// Optional miss counter: define SARGANTANA_ICACHE_MISS_CNT_EN to build it.
// Without it, miss_cnt_o is tied to zero.
module sargantana_icache_ctrl #(
   parameter  int N_WAY      = 4,
   parameter  int N_SETS     = 64,
   parameter  int FILL_BEATS = 2,
   localparam int WAY_W      = (N_WAY > 1) ? $clog2(N_WAY) : 1,
   localparam int SET_W      = (N_SETS > 1) ? $clog2(N_SETS) : 1,
   localparam int BEAT_W     = (FILL_BEATS > 1) ? $clog2(FILL_BEATS) : 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              ireq_valid_i,
   output logic              ireq_ready_o,
   input  logic              ireq_kill_i,
   input  logic              flush_i,
   input  logic              cache_enable_i,
   input  logic              tresp_valid_i,
   input  logic              tresp_xcpt_i,
   input  logic              tag_hit_i,
   input  logic [N_WAY-1:0]  way_valid_i,
   output logic              cmp_enable_o,
   output logic [WAY_W-1:0]  way_to_replace_o,
   output logic              ifill_req_valid_o,
   input  logic              ifill_req_ready_i,
   input  logic              ifill_resp_valid_i,
   output logic              data_we_o,
   output logic [BEAT_W-1:0] beat_idx_o,
   output logic              tag_we_o,
   output logic              ifill_started_o,
   output logic              flush_en_o,
   output logic [SET_W-1:0]  flush_idx_o,
   output logic              resp_valid_o,
   output logic              resp_xcpt_o,
   output logic              busy_o,
   output logic [31:0]       miss_cnt_o
);

   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FILL_BEATS - 1);
   localparam logic [SET_W-1:0]  LAST_SET  = SET_W'(N_SETS - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      COMPARE   = 3'd1,
      MISS_REQ  = 3'd2,
      MISS_WAIT = 3'd3,
      REPLAY    = 3'd4,
      FLUSH     = 3'd5
   } state_t;

   state_t             state;
   state_t             next_state;
   logic               cen_q;
   logic [WAY_W-1:0]   victim_q;
   logic               all_valid_q;
   logic [WAY_W-1:0]   rr_ptr;
   logic [BEAT_W-1:0]  beat_cnt;
   logic [SET_W-1:0]   flush_cnt;
   logic               kill_pend;
   logic               flush_pend;

   logic               req_accept;
   logic               start_miss;
   logic               fill_accept;
   logic               fill_beat;
   logic               last_beat;
   logic               flush_last;
   logic               all_valid;
   logic               in_fill;

   // Lowest-index way whose valid bit is clear (0 when none is clear).
   function automatic logic [WAY_W-1:0] first_invalid(input logic [N_WAY-1:0] v);
      logic [WAY_W-1:0] idx;
      idx = '0;
      for (int i = N_WAY - 1; i >= 0; i--) begin
         if (!v[i]) begin
            idx = WAY_W'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

   assign all_valid        = &way_valid_i;
   assign in_fill          = (state == MISS_REQ) || (state == MISS_WAIT);
   assign busy_o           = (state != IDLE);
   assign way_to_replace_o = victim_q;

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state selection and the combinational strobes seen by the stage.
   always_comb begin
      next_state        = state;
      ireq_ready_o      = 1'b0;
      cmp_enable_o      = 1'b0;
      ifill_req_valid_o = 1'b0;
      data_we_o         = 1'b0;
      beat_idx_o        = '0;
      tag_we_o          = 1'b0;
      ifill_started_o   = 1'b0;
      flush_en_o        = 1'b0;
      flush_idx_o       = '0;
      resp_valid_o      = 1'b0;
      resp_xcpt_o       = 1'b0;
      req_accept        = 1'b0;
      start_miss        = 1'b0;
      fill_accept       = 1'b0;
      fill_beat         = 1'b0;
      last_beat         = 1'b0;
      flush_last        = 1'b0;
      case (state)
         IDLE: begin
            ireq_ready_o = !flush_i;
            if (flush_i) begin
               next_state = FLUSH;
            end else if (ireq_valid_i) begin
               req_accept = 1'b1;
               next_state = COMPARE;
            end else begin
               next_state = IDLE;
            end
         end
         COMPARE: begin
            cmp_enable_o = tresp_valid_i;
            if (ireq_kill_i) begin
               next_state = IDLE;
            end else if (tresp_valid_i) begin
               if (tresp_xcpt_i) begin
                  resp_valid_o = 1'b1;
                  resp_xcpt_o  = 1'b1;
                  next_state   = IDLE;
               end else if (tag_hit_i && cen_q) begin
                  resp_valid_o = 1'b1;
                  next_state   = IDLE;
               end else begin
                  start_miss = 1'b1;
                  next_state = MISS_REQ;
               end
            end else begin
               next_state = COMPARE;
            end
         end
         MISS_REQ: begin
            ifill_req_valid_o = 1'b1;
            ifill_started_o   = 1'b1;
            if (ifill_req_ready_i) begin
               fill_accept = 1'b1;
               next_state  = MISS_WAIT;
            end else begin
               next_state = MISS_REQ;
            end
         end
         MISS_WAIT: begin
            ifill_started_o = 1'b1;
            if (ifill_resp_valid_i) begin
               fill_beat  = 1'b1;
               data_we_o  = cen_q;
               beat_idx_o = beat_cnt;
               if (beat_cnt == LAST_BEAT) begin
                  // The line is complete: tag goes valid together with the last beat.
                  last_beat = 1'b1;
                  tag_we_o  = cen_q;
                  if (flush_pend || flush_i) begin
                     next_state = FLUSH;
                  end else if (kill_pend || ireq_kill_i) begin
                     next_state = IDLE;
                  end else begin
                     next_state = REPLAY;
                  end
               end else begin
                  next_state = MISS_WAIT;
               end
            end else begin
               next_state = MISS_WAIT;
            end
         end
         REPLAY: begin
            resp_valid_o = !ireq_kill_i;
            next_state   = IDLE;
         end
         FLUSH: begin
            flush_en_o  = 1'b1;
            flush_idx_o = flush_cnt;
            if (flush_cnt == LAST_SET) begin
               flush_last = 1'b1;
               next_state = IDLE;
            end else begin
               next_state = FLUSH;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Request context, victim choice, beat/set counters and deferred kill/flush.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cen_q       <= 1'b0;
         victim_q    <= '0;
         all_valid_q <= 1'b0;
         rr_ptr      <= '0;
         beat_cnt    <= '0;
         flush_cnt   <= '0;
         kill_pend   <= 1'b0;
         flush_pend  <= 1'b0;
      end else begin
         if (req_accept) begin
            cen_q <= cache_enable_i;
         end
         if (start_miss) begin
            victim_q    <= all_valid ? rr_ptr : first_invalid(way_valid_i);
            all_valid_q <= all_valid;
         end
         if (fill_accept || last_beat) begin
            beat_cnt <= '0;
         end else if (fill_beat) begin
            beat_cnt <= beat_cnt + BEAT_W'(1);
         end
         // Kill/flush cannot interrupt a fill; remember them until the last beat.
         if (last_beat || flush_last) begin
            kill_pend  <= 1'b0;
            flush_pend <= 1'b0;
         end else if (in_fill) begin
            kill_pend  <= kill_pend | ireq_kill_i;
            flush_pend <= flush_pend | flush_i;
         end
         // Round-robin only advances when a valid way was actually displaced.
         if (flush_last) begin
            rr_ptr <= '0;
         end else if (last_beat && cen_q && all_valid_q) begin
            rr_ptr <= rr_ptr + WAY_W'(1);
         end
         if (flush_last) begin
            flush_cnt <= '0;
         end else if (state == FLUSH) begin
            flush_cnt <= flush_cnt + SET_W'(1);
         end
      end
   end

`ifdef SARGANTANA_ICACHE_MISS_CNT_EN
   logic [31:0] miss_cnt;

   // Saturating miss counter; survives flushes, cleared only by reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         miss_cnt <= 32'd0;
      end else if (start_miss && (miss_cnt != 32'hFFFF_FFFF)) begin
         miss_cnt <= miss_cnt + 32'd1;
      end
   end

   assign miss_cnt_o = miss_cnt;
`else
   assign miss_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_sargantana_icache_ctrl.sv
// Scoreboard bench for sargantana_icache_ctrl: transactions push expected
// output events; a negedge monitor pops and compares what the DUT presents.
module tb_sargantana_icache_ctrl;
   localparam int N_WAY = 4, N_SETS = 64, FILL_BEATS = 2;
   localparam int EV_RESP = 0, EV_DWE = 1, EV_TWE = 2, EV_FLS = 3, EV_FREQ = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_i, ireq_valid_i, ireq_ready_o, ireq_kill_i, flush_i, cache_enable_i;
   logic tresp_valid_i, tresp_xcpt_i, tag_hit_i;
   logic [N_WAY-1:0] way_valid_i;
   logic cmp_enable_o;
   logic [1:0] way_to_replace_o;
   logic ifill_req_valid_o, ifill_req_ready_i, ifill_resp_valid_i;
   logic data_we_o;
   logic [0:0] beat_idx_o;
   logic tag_we_o, ifill_started_o, flush_en_o;
   logic [5:0] flush_idx_o;
   logic resp_valid_o, resp_xcpt_o, busy_o;
   logic [31:0] miss_cnt_o;

   sargantana_icache_ctrl #(.N_WAY(N_WAY), .N_SETS(N_SETS), .FILL_BEATS(FILL_BEATS)) dut (
      .clk_i(clk), .rst_i(rst_i), .ireq_valid_i(ireq_valid_i), .ireq_ready_o(ireq_ready_o),
      .ireq_kill_i(ireq_kill_i), .flush_i(flush_i), .cache_enable_i(cache_enable_i),
      .tresp_valid_i(tresp_valid_i), .tresp_xcpt_i(tresp_xcpt_i), .tag_hit_i(tag_hit_i),
      .way_valid_i(way_valid_i), .cmp_enable_o(cmp_enable_o), .way_to_replace_o(way_to_replace_o),
      .ifill_req_valid_o(ifill_req_valid_o), .ifill_req_ready_i(ifill_req_ready_i),
      .ifill_resp_valid_i(ifill_resp_valid_i), .data_we_o(data_we_o), .beat_idx_o(beat_idx_o),
      .tag_we_o(tag_we_o), .ifill_started_o(ifill_started_o), .flush_en_o(flush_en_o),
      .flush_idx_o(flush_idx_o), .resp_valid_o(resp_valid_o), .resp_xcpt_o(resp_xcpt_o),
      .busy_o(busy_o), .miss_cnt_o(miss_cnt_o));

   typedef struct { int kind; int a; int b; } ev_t;
   ev_t exp_q[$];
   int checks = 0;
   int failures = 0;
   int rr_m = 0;     // model round-robin pointer
   int miss_m = 0;   // model miss count

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic push(input int k, input int a, input int b);
      ev_t e;
      e.kind = k; e.a = a; e.b = b;
      exp_q.push_back(e);
   endtask

   task automatic observe(input int k, input int a, input int b);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL unexpected_event: got kind=%0d a=%0d b=%0d, expected none (t=%0t)", k, a, b, $time);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != k || e.a != a || e.b != b) begin
            failures++;
            $display("FAIL event: got kind=%0d a=%0d b=%0d, expected kind=%0d a=%0d b=%0d (t=%0t)",
                     k, a, b, e.kind, e.a, e.b, $time);
         end
      end
   endtask

   // Monitor: turn every output strobe into an event and check it against the queue.
   always @(negedge clk) begin
      if (!rst_i) begin
         if (resp_valid_o) observe(EV_RESP, int'(resp_xcpt_o), 0);
         if (ifill_req_valid_o && ifill_req_ready_i) observe(EV_FREQ, int'(way_to_replace_o), 0);
         if (data_we_o) observe(EV_DWE, int'(beat_idx_o), int'(way_to_replace_o));
         if (tag_we_o) observe(EV_TWE, int'(way_to_replace_o), 0);
         if (flush_en_o) observe(EV_FLS, int'(flush_idx_o), 0);
      end
   end

   function automatic int model_victim(input logic [N_WAY-1:0] wv);
      for (int i = 0; i < N_WAY; i++) if (!wv[i]) return i;
      return rr_m;
   endfunction

   function automatic int exp_miss();
`ifdef SARGANTANA_ICACHE_MISS_CNT_EN
      return miss_m;
`else
      return 0;
`endif
   endfunction

   task automatic push_flush();
      for (int i = 0; i < N_SETS; i++) push(EV_FLS, i, 0);
      rr_m = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs();
      @(negedge clk);
      chk("rst_ready", int'(ireq_ready_o), 1);
      chk("rst_busy", int'(busy_o), 0);
      chk("rst_strobes", int'({cmp_enable_o, ifill_req_valid_o, data_we_o, tag_we_o,
                               ifill_started_o, flush_en_o, resp_valid_o, resp_xcpt_o}), 0);
      chk("rst_way", int'(way_to_replace_o), 0);
      chk("rst_miss_cnt", int'(miss_cnt_o), 0);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (!busy_o) return;
      end
      checks++;
      failures++;
      $display("FAIL wait_idle: got busy after 400 cycles, expected idle");
   endtask

   // kill_mode: 0 none, 1 in MISS_REQ, 2 after beat 0, 3 in COMPARE, 4 in REPLAY.
   // flush_mode: 1 raises flush after beat 0. rdel < 0 picks a random ready delay.
   task automatic fetch(input bit cen, input bit xcpt, input bit hit, input logic [N_WAY-1:0] wv,
                        input int kill_mode, input int flush_mode, input int rdel);
      int d, r, vic;
      bit miss, sup;
      step(); ireq_valid_i = 1'b1; cache_enable_i = cen;
      step(); ireq_valid_i = 1'b0; cache_enable_i = 1'($urandom_range(0, 1));
      d = $urandom_range(0, 2);
      repeat (d) begin ifill_resp_valid_i = 1'($urandom_range(0, 1)); step(); end
      ifill_resp_valid_i = 1'b0;
      if (kill_mode == 3) begin
         ireq_kill_i = 1'b1; tresp_valid_i = 1'b1; tag_hit_i = 1'b1; tresp_xcpt_i = xcpt;
         step();
         ireq_kill_i = 1'b0; tresp_valid_i = 1'b0; tag_hit_i = 1'b0; tresp_xcpt_i = 1'b0;
         return;
      end
      tresp_valid_i = 1'b1; tresp_xcpt_i = xcpt; tag_hit_i = hit; way_valid_i = wv;
      miss = !xcpt && !(hit && cen);
      if (xcpt) push(EV_RESP, 1, 0);
      else if (!miss) push(EV_RESP, 0, 0);
      else begin
         vic = model_victim(wv);
         miss_m++;
         push(EV_FREQ, vic, 0);
         for (int b = 0; b < FILL_BEATS; b++) begin
            if (cen) begin
               push(EV_DWE, b, vic);
               if (b == FILL_BEATS - 1) push(EV_TWE, vic, 0);
            end
         end
         sup = (kill_mode == 1) || (kill_mode == 2) || (kill_mode == 4) || (flush_mode == 1);
         if (!sup) push(EV_RESP, 0, 0);
         if (cen && wv == {N_WAY{1'b1}}) rr_m = (rr_m + 1) % N_WAY;
         if (flush_mode == 1) push_flush();
      end
      @(negedge clk);
      chk("cmp_enable", int'(cmp_enable_o), 1);
      if (!miss) chk("resp_with_cmp", int'(resp_valid_o), 1);
      step();
      tresp_valid_i = 1'b0; tresp_xcpt_i = 1'b0; tag_hit_i = 1'b0;
      way_valid_i = N_WAY'($urandom_range(0, 15));
      if (!miss) return;
      r = (rdel < 0) ? $urandom_range(0, 3) : rdel;
      for (int i = 0; i < r; i++) begin
         ifill_resp_valid_i = 1'($urandom_range(0, 1));
         ireq_kill_i = (kill_mode == 1 && i == 0);
         @(negedge clk);
         chk("ifill_req_held", int'(ifill_req_valid_o), 1);
         step();
      end
      ifill_resp_valid_i = 1'b0;
      ireq_kill_i = (kill_mode == 1 && r == 0);
      ifill_req_ready_i = 1'b1;
      step();
      ifill_req_ready_i = 1'b0; ireq_kill_i = 1'b0;
      for (int b = 0; b < FILL_BEATS; b++) begin
         if (b == 1 && (kill_mode == 2 || flush_mode == 1)) begin
            ireq_kill_i = (kill_mode == 2); flush_i = (flush_mode == 1);
            step();
            ireq_kill_i = 1'b0; flush_i = 1'b0;
         end
         repeat ($urandom_range(0, 2)) step();
         ifill_resp_valid_i = 1'b1;
         step();
         ifill_resp_valid_i = 1'b0;
      end
      if (kill_mode == 4) begin
         ireq_kill_i = 1'b1;
         step();
         ireq_kill_i = 1'b0;
      end
   endtask

   task automatic txn(input bit cen, input bit xcpt, input bit hit, input logic [N_WAY-1:0] wv,
                      input int kill_mode, input int flush_mode, input int rdel);
      fetch(cen, xcpt, hit, wv, kill_mode, flush_mode, rdel);
      wait_idle();
      if ($urandom_range(0, 2) == 0) begin
         step(); ifill_resp_valid_i = 1'b1;
         step(); ifill_resp_valid_i = 1'b0;
      end
   endtask

   task automatic flush_from_idle();
      step();
      flush_i = 1'b1; ireq_valid_i = 1'b1;
      push_flush();
      @(negedge clk);
      chk("ready_low_on_flush", int'(ireq_ready_o), 0);
      step();
      ireq_valid_i = 1'b0;
      for (int i = 0; i < N_SETS; i++) begin
         flush_i = (i == 10);
         @(negedge clk);
         chk("ready_in_flush", int'(ireq_ready_o), 0);
         step();
      end
      flush_i = 1'b0;
      @(negedge clk);
      chk("flush_duration", int'(busy_o), 0);
   endtask

   initial begin
      rst_i = 1'b1; ireq_valid_i = 1'b0; ireq_kill_i = 1'b0; flush_i = 1'b0; cache_enable_i = 1'b0;
      tresp_valid_i = 1'b0; tresp_xcpt_i = 1'b0; tag_hit_i = 1'b0; way_valid_i = '0;
      ifill_req_ready_i = 1'b0; ifill_resp_valid_i = 1'b0;
      repeat (3) step();
      rst_i = 1'b0;
      check_reset_outputs();

      txn(1'b1, 1'b0, 1'b1, 4'hF, 0, 0, -1);          // hit
      txn(1'b1, 1'b0, 1'b0, 4'b0111, 0, 0, 3);        // miss, way 3 free
      chk("miss_cnt_after_first_miss", int'(miss_cnt_o), exp_miss());
      for (int i = 0; i < 5; i++) txn(1'b1, 1'b0, 1'b0, 4'hF, 0, 0, -1);  // round-robin 0,1,2,3,0
      flush_from_idle();
      txn(1'b1, 1'b0, 1'b0, 4'hF, 0, 0, -1);          // pointer back at 0
      txn(1'b1, 1'b0, 1'b0, 4'b0001, 2, 0, -1);       // kill after beat 0
      txn(1'b1, 1'b0, 1'b0, 4'hF, 0, 1, -1);          // flush during MISS_WAIT
      txn(1'b1, 1'b1, 1'b0, 4'hF, 0, 0, -1);          // translation exception
      txn(1'b1, 1'b0, 1'b0, 4'hF, 3, 0, -1);          // kill in COMPARE
      txn(1'b1, 1'b0, 1'b0, 4'b1011, 1, 0, 2);        // kill in MISS_REQ
      txn(1'b1, 1'b0, 1'b0, 4'b1110, 4, 0, -1);       // kill in REPLAY
      txn(1'b0, 1'b0, 1'b1, 4'hF, 0, 0, -1);          // uncached: fill without writes
      chk("miss_cnt_directed", int'(miss_cnt_o), exp_miss());

      // Reset while in MISS_WAIT after beat 0, then stray beats.
      step(); ireq_valid_i = 1'b1; cache_enable_i = 1'b1;
      step(); ireq_valid_i = 1'b0;
      tresp_valid_i = 1'b1; way_valid_i = 4'b0011; tag_hit_i = 1'b0;
      push(EV_FREQ, 2, 0); push(EV_DWE, 0, 2);
      step(); tresp_valid_i = 1'b0; ifill_req_ready_i = 1'b1;
      step(); ifill_req_ready_i = 1'b0; ifill_resp_valid_i = 1'b1;
      step(); ifill_resp_valid_i = 1'b0; rst_i = 1'b1;
      step(); rst_i = 1'b0;
      rr_m = 0; miss_m = 0;
      check_reset_outputs();
      step(); ifill_resp_valid_i = 1'b1;
      repeat (3) step();
      ifill_resp_valid_i = 1'b0;

      for (int n = 0; n < 60; n++) begin
         bit c, x, h;
         logic [N_WAY-1:0] wv;
         int km, fm;
         c  = ($urandom_range(0, 7) != 0);
         x  = ($urandom_range(0, 7) == 0);
         h  = ($urandom_range(0, 2) == 0);
         wv = ($urandom_range(0, 2) == 0) ? 4'hF : N_WAY'($urandom_range(0, 15));
         km = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
         fm = ($urandom_range(0, 9) == 0) ? 1 : 0;
         txn(c, x, h, wv, km, fm, -1);
      end
      chk("miss_cnt_final", int'(miss_cnt_o), exp_miss());
      repeat (2) step();
      chk("queue_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/sargantana_icache_ctrl.md
Name: sargantana_icache_ctrl

Overview:
- Sequencing controller for the instruction-cache pipeline stage.
- Accepts fetch requests, waits for the translation response, then enables tag comparison.
- On a miss, picks a victim way, issues the line-fill request and counts returned beats, then replays the response.
- Walks all sets on a flush.
- Drives the stage register enables: cmp_enable, flush, way_to_replace, ifill_process_started, valid_ireq, ireq_kill.

Parameters:
- N_WAY, 4, number of ways (power of 2, ≥2)
- N_SETS, 64, number of sets (power of 2)
- FILL_BEATS, 2, response beats per line fill (≥1)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high (one clock domain)
- ireq_valid_i  in  1  fetch request valid
- ireq_ready_o  out  1  controller can accept a request
- ireq_kill_i  in  1  kill the in-flight request
- flush_i  in  1  invalidate the whole cache
- cache_enable_i  in  1  cacheable mode; sampled at request accept
- tresp_valid_i  in  1  MMU translation response valid
- tresp_xcpt_i  in  1  translation exception
- tag_hit_i  in  1  comparator hit, valid while cmp_enable_o=1
- way_valid_i  in  N_WAY  valid bits of the indexed set
- cmp_enable_o  out  1  enable tag comparison this cycle
- way_to_replace_o  out  log2(N_WAY)  victim way
- ifill_req_valid_o  out  1  line-fill request valid
- ifill_req_ready_i  in  1  L2 accepts the fill request
- ifill_resp_valid_i  in  1  one fill beat returned
- data_we_o  out  1  write the current beat into the data array
- beat_idx_o  out  log2(FILL_BEATS) (min 1)  beat index of the write
- tag_we_o  out  1  write tag and set valid for the victim way
- ifill_started_o  out  1  a fill is outstanding
- flush_en_o  out  1  invalidate the set at flush_idx_o
- flush_idx_o  out  log2(N_SETS)  set being invalidated
- resp_valid_o  out  1  one-cycle fetch response
- resp_xcpt_o  out  1  response carries an exception
- busy_o  out  1  state ≠ IDLE
- miss_cnt_o  out  32  miss counter (see Optional Feature)

Behaviour:
- Reset: state=IDLE; all outputs 0 except ireq_ready_o=1; all counters, the round-robin pointer and all pending flags are 0.
- Reset mid-operation abandons the current state. Fill beats arriving after reset are ignored in IDLE (no writes).
- States: IDLE, COMPARE, MISS_REQ, MISS_WAIT, REPLAY, FLUSH.
- IDLE:
  - ireq_ready_o = !flush_i.
  - flush_i → FLUSH. Flush has priority over a simultaneous request.
  - Else ireq_valid_i → COMPARE; latch cache_enable_i as cen_q.
- COMPARE:
  - cmp_enable_o = tresp_valid_i.
  - ireq_kill_i (any cycle, priority) → IDLE, no response.
  - On tresp_valid_i with tresp_xcpt_i: resp_valid_o=1, resp_xcpt_o=1 → IDLE.
  - On tresp_valid_i with tag_hit_i & cen_q: resp_valid_o=1 → IDLE.
  - Otherwise on tresp_valid_i → MISS_REQ.
  - Victim is latched on that transition: the lowest-index invalid way in way_valid_i; if all ways are valid, the round-robin pointer.
- MISS_REQ:
  - ifill_req_valid_o=1 and ifill_started_o=1.
  - ifill_req_valid_o is held until ifill_req_ready_i; it is never withdrawn.
  - On accept → MISS_WAIT, beat_cnt=0.
- MISS_WAIT:
  - ifill_started_o=1.
  - Each ifill_resp_valid_i: data_we_o=cen_q, beat_idx_o=beat_cnt, beat_cnt+1.
  - On the beat with beat_cnt==FILL_BEATS-1, also tag_we_o=cen_q.
  - If cen_q and all ways were valid, the round-robin pointer increments mod N_WAY on that beat.
  - Exit on the last beat: flush_pend → FLUSH; else kill_pend → IDLE; else → REPLAY.
- Kill or flush during MISS_REQ/MISS_WAIT:
  - ireq_kill_i sets kill_pend; flush_i sets flush_pend.
  - The fill always completes and writes tag and data, so the line is never left partially overwritten under a valid tag.
  - Any pending kill or flush suppresses the response.
- REPLAY: resp_valid_o=1 for one cycle → IDLE. ireq_kill_i in this cycle suppresses resp_valid_o.
- FLUSH:
  - flush_en_o=1; flush_idx_o = set counter, starting at 0 and incrementing each cycle.
  - After idx N_SETS-1 → IDLE, which clears the counter, the round-robin pointer and the pending flags.
  - flush_i during FLUSH is ignored. Total duration is exactly N_SETS cycles.
- Output timing:
  - All strobe outputs are combinational from state and inputs; they are registered downstream.
  - ireq_ready_o=0 outside IDLE.
- Lost-event guard: ifill_resp_valid_i outside MISS_WAIT produces no writes.

Optional Feature:
- Macro: SARGANTANA_ICACHE_MISS_CNT_EN.
- Defined:
  - 32-bit miss_cnt_o increments on each COMPARE→MISS_REQ transition.
  - It saturates at 0xFFFFFFFF, is cleared by rst_i and is not cleared by flush.
- Undefined: the counter logic is absent and miss_cnt_o is tied to 0.

Test Plan:
1. Hit: request, tresp_valid_i with hit=1 and cen=1 two cycles later → cmp_enable_o=1 in that cycle, resp_valid_o=1 in the same cycle, back in IDLE next cycle, ifill_req_valid_o never asserted.
2. Miss, set not full: way_valid_i=4'b0111, ready delayed 3 cycles, FILL_BEATS=2 → way_to_replace_o=3, request held 3 cycles, data_we_o with beat_idx 0 then 1, tag_we_o on beat 1, resp_valid_o one cycle later, miss_cnt_o=1 (macro on).
3. Round-robin: four misses with all ways valid → victims 0,1,2,3, fifth miss → 0. A flush in between resets the pointer to 0.
4. Kill mid-fill: ireq_kill_i after beat 0 → beat 1 still writes with tag_we_o=1, no resp_valid_o, IDLE after the last beat.
5. Flush: flush_i together with ireq_valid_i in IDLE → FLUSH, flush_idx_o 0..63 over 64 cycles, ireq_ready_o=0 throughout. Flush during MISS_WAIT → entered only after the last beat, no response.
6. Exception / reset: tresp_xcpt_i=1 → resp_valid_o=1 and resp_xcpt_o=1, no fill. rst_i in MISS_WAIT → IDLE next cycle with all outputs at reset values; stray beats ignored.
